// File: rtl/nios_qsys_shared_memory_pkg.sv
// Shared constants for the dual-port shared memory with mailbox interrupts.
package nios_qsys_shared_memory_pkg;

  // Default geometry and read pipeline depth.
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_OUT_REG = 0;

  // Mailbox word offsets relative to MBOX_ADDR.
  localparam int MBOX_OFS_P1_TO_P2 = 0;
  localparam int MBOX_OFS_P2_TO_P1 = 1;

  // Sticky interrupt update: a set in the same cycle as a clear wins.
  function automatic logic irq_next(input logic cur, input logic set_i, input logic clr_i);
    return set_i | (cur & ~clr_i);
  endfunction

endpackage

// File: rtl/nios_qsys_shared_memory_rdpipe.sv
// Read-valid/data pipeline for one port. Depth is 1 + OUT_REG.
// Stage 0 data lives in the RAM output register (owned by the top); this
// block tracks validity and adds the optional output register. While clken
// is low every stage holds and the output valid is masked.
module nios_qsys_shared_memory_rdpipe #(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              rd_acc,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic v0_q, v0_d;

  // Stage 0 valid follows accepted reads only while the port is enabled.
  always_comb begin
    v0_d = v0_q;
    if (clken) v0_d = rd_acc;
  end

  // Stage 0 valid register; reset discards reads in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) v0_q <= 1'b0;
    else       v0_q <= v0_d;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              v1_q, v1_d;
    logic [DATA_W-1:0] d1_q, d1_d;

    // Output stage advances on enabled cycles; data only reloads on a real
    // read so readdata holds its last value between pulses.
    always_comb begin
      v1_d = v1_q;
      d1_d = d1_q;
      if (clken) begin
        v1_d = v0_q;
        if (v0_q) d1_d = ram_data;
      end
    end

    // Output stage registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v1_q <= 1'b0;
        d1_q <= '0;
      end else begin
        v1_q <= v1_d;
        d1_q <= d1_d;
      end
    end

    assign rdata  = d1_q;
    assign rvalid = v1_q & clken;
  end else begin : g_no_out_reg
    assign rdata  = ram_data;
    assign rvalid = v0_q & clken;
  end

endmodule

// File: rtl/nios_qsys_shared_memory_mbox.sv
// True dual-port shared memory with byte enables and a mailbox word per
// direction. Writing a mailbox raises the other port's sticky irq; the other
// port reading it clears the irq.
module nios_qsys_shared_memory_mbox
  import nios_qsys_shared_memory_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int OUT_REG   = DEF_OUT_REG,
  parameter int MBOX_ADDR = 2**ADDR_W - 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   address,
  input  logic [ADDR_W-1:0]   address2,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W/8-1:0] byteenable2,
  input  logic                chipselect,
  input  logic                chipselect2,
  input  logic                read,
  input  logic                read2,
  input  logic                write,
  input  logic                write2,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   writedata2,
  input  logic                clken,
  input  logic                clken2,
  output logic [DATA_W-1:0]   readdata,
  output logic [DATA_W-1:0]   readdata2,
  output logic                readdatavalid,
  output logic                readdatavalid2,
  output logic                irq,
  output logic                irq2
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 2**ADDR_W;
  // Mailbox addresses wrap modulo the memory depth.
  localparam logic [ADDR_W-1:0] MBOX_P1_TO_P2 = ADDR_W'(MBOX_ADDR + MBOX_OFS_P1_TO_P2);
  localparam logic [ADDR_W-1:0] MBOX_P2_TO_P1 = ADDR_W'(MBOX_ADDR + MBOX_OFS_P2_TO_P1);

  logic wr1_acc, rd1_acc, wr2_acc, rd2_acc;
  logic [DATA_W-1:0] ram_rd1, ram_rd2;
  logic irq_q, irq_d, irq2_q, irq2_d;

  assign wr1_acc = chipselect  & write  & clken  & ~reset_req;
  assign rd1_acc = chipselect  & read   & clken  & ~reset_req;
  assign wr2_acc = chipselect2 & write2 & clken2 & ~reset_req;
  assign rd2_acc = chipselect2 & read2  & clken2 & ~reset_req;

  // One byte-wide RAM per lane keeps byte enables and the port-1 priority
  // on address collisions simple for block RAM inference.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd1_q, rd2_q;

    // Writes: port 2 first so port 1 overrides on a shared byte.
    always_ff @(posedge clk) begin
      if (wr2_acc && byteenable2[gi]) mem[address2] <= writedata2[gi*8 +: 8];
      if (wr1_acc && byteenable[gi])  mem[address]  <= writedata[gi*8 +: 8];
    end

    // Registered reads return the pre-write contents; cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        if (rd1_acc) rd1_q <= mem[address];
        if (rd2_acc) rd2_q <= mem[address2];
      end
    end

    assign ram_rd1[gi*8 +: 8] = rd1_q;
    assign ram_rd2[gi*8 +: 8] = rd2_q;
  end

  nios_qsys_shared_memory_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rdpipe1 (
    .clk(clk), .reset(reset), .clken(clken), .rd_acc(rd1_acc),
    .ram_data(ram_rd1), .rdata(readdata), .rvalid(readdatavalid)
  );

  nios_qsys_shared_memory_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rdpipe2 (
    .clk(clk), .reset(reset), .clken(clken2), .rd_acc(rd2_acc),
    .ram_data(ram_rd2), .rdata(readdata2), .rvalid(readdatavalid2)
  );

  // Mailbox interrupts: writer sets the peer's irq, the peer's read clears it.
  always_comb begin
    irq2_d = irq_next(irq2_q, wr1_acc && (address == MBOX_P1_TO_P2),
                      rd2_acc && (address2 == MBOX_P1_TO_P2));
    irq_d  = irq_next(irq_q, wr2_acc && (address2 == MBOX_P2_TO_P1),
                      rd1_acc && (address == MBOX_P2_TO_P1));
  end

  // Interrupt state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q  <= 1'b0;
      irq2_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      irq2_q <= irq2_d;
    end
  end

  assign irq  = irq_q;
  assign irq2 = irq2_q;

endmodule

// File: tb/tb_nios_qsys_shared_memory_mbox.sv
// Bench: two instances (OUT_REG=0 and OUT_REG=1) share one stimulus stream.
// A word-level memory/irq model produces expected read data; per-port
// monitors pop expectations when the read has seen 1+OUT_REG enabled cycles.
`timescale 1ns/1ps
module tb_nios_qsys_shared_memory_mbox;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int MB    = DEPTH - 2;

  typedef struct {
    logic [31:0] data;
    int          born;
    int          cnt;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset, reset_req;
  logic [AW-1:0] address, address2;
  logic [3:0]  byteenable, byteenable2;
  logic        chipselect, chipselect2, read, read2, write, write2, clken, clken2;
  logic [31:0] writedata, writedata2;
  logic        irq_w [2];
  logic        irq2_w [2];
  wire  [1:0]  ce = {clken2, clken};

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [DEPTH];
  bit          exp_irq, exp_irq2;
  logic [1:0]  iss;
  logic [31:0] iss_d [2];
  bit          final_chk;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = 1 + gi;
    logic [31:0] rdd [2];
    logic [1:0]  rdv;

    nios_qsys_shared_memory_mbox #(.DATA_W(32), .ADDR_W(AW), .OUT_REG(gi)) dut (
      .clk(clk), .reset(reset), .reset_req(reset_req),
      .address(address), .address2(address2),
      .byteenable(byteenable), .byteenable2(byteenable2),
      .chipselect(chipselect), .chipselect2(chipselect2),
      .read(read), .read2(read2), .write(write), .write2(write2),
      .writedata(writedata), .writedata2(writedata2),
      .clken(clken), .clken2(clken2),
      .readdata(rdd[0]), .readdata2(rdd[1]),
      .readdatavalid(rdv[0]), .readdatavalid2(rdv[1]),
      .irq(irq_w[gi]), .irq2(irq2_w[gi])
    );

    for (genvar gp = 0; gp < 2; gp++) begin : g_port
      sb_t q[$];
      bit  done_chk = 1'b0;

      always @(negedge clk) begin
        bit  hit;
        sb_t e;
        if (reset) begin
          q.delete();
          checks++;
          if (rdv[gp] !== 1'b0 || rdd[gp] !== 32'h0) begin
            errors++;
            $display("FAIL reset_out dut%0d p%0d cyc=%0d: valid=%b data=%h, required valid=0 data=0",
                     gi, gp + 1, cyc, rdv[gp], rdd[gp]);
          end
        end else begin
          hit = (q.size() > 0) && ce[gp] && (q[0].born < cyc) && (q[0].cnt + 1 == LAT);
          if (hit || rdv[gp] !== 1'b0) begin
            checks++;
            if (!hit) begin
              errors++;
              $display("FAIL unexpected_valid dut%0d p%0d cyc=%0d: valid=%b data=%h, required valid=0",
                       gi, gp + 1, cyc, rdv[gp], rdd[gp]);
            end else if (rdv[gp] !== 1'b1) begin
              errors++;
              $display("FAIL missing_valid dut%0d p%0d cyc=%0d: valid=%b, required valid=1 data=%h",
                       gi, gp + 1, cyc, rdv[gp], q[0].data);
            end else if (rdd[gp] !== q[0].data) begin
              errors++;
              $display("FAIL rd_data dut%0d p%0d cyc=%0d: got %h required %h",
                       gi, gp + 1, cyc, rdd[gp], q[0].data);
            end else begin
              $display("read dut%0d p%0d cyc=%0d data=%h ok", gi, gp + 1, cyc, rdd[gp]);
            end
            if (hit) void'(q.pop_front());
          end
          if (ce[gp]) begin
            foreach (q[i]) if (q[i].born < cyc) q[i].cnt = q[i].cnt + 1;
          end
          if (iss[gp]) begin
            e.data = iss_d[gp];
            e.born = cyc;
            e.cnt  = 0;
            q.push_back(e);
          end
          if (final_chk && !done_chk) begin
            done_chk = 1'b1;
            checks++;
            if (q.size() != 0) begin
              errors++;
              $display("FAIL drain dut%0d p%0d: %0d reads outstanding, required 0", gi, gp + 1, q.size());
            end
          end
        end
      end
    end
  end

  task automatic idle();
    chipselect = 0; read = 0; write = 0; address = '0; byteenable = '0; writedata = '0;
    chipselect2 = 0; read2 = 0; write2 = 0; address2 = '0; byteenable2 = '0; writedata2 = '0;
    clken = 1; clken2 = 1; reset_req = 0;
  endtask

  task automatic set_p1(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    chipselect = rd | wr; read = rd; write = wr; address = a; byteenable = be; writedata = d;
  endtask

  task automatic set_p2(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    chipselect2 = rd | wr; read2 = rd; write2 = wr; address2 = a; byteenable2 = be; writedata2 = d;
  endtask

  // One clock cycle: apply the reference model to the current inputs,
  // hand expected reads to the monitors, then check the irq outputs.
  task automatic step();
    bit w1, r1, w2, r2, s1, c1, s2, c2;
    w1 = !reset && chipselect  && write  && clken  && !reset_req;
    r1 = !reset && chipselect  && read   && clken  && !reset_req;
    w2 = !reset && chipselect2 && write2 && clken2 && !reset_req;
    r2 = !reset && chipselect2 && read2  && clken2 && !reset_req;
    iss      = {r2, r1};
    iss_d[0] = mdl[address];
    iss_d[1] = mdl[address2];
    s2 = w1 && (address  == AW'(MB));
    c2 = r2 && (address2 == AW'(MB));
    s1 = w2 && (address2 == AW'(MB + 1));
    c1 = r1 && (address  == AW'(MB + 1));
    if (reset) begin
      exp_irq  = 1'b0;
      exp_irq2 = 1'b0;
    end else begin
      exp_irq2 = s2 || (exp_irq2 && !c2);
      exp_irq  = s1 || (exp_irq && !c1);
    end
    for (int b = 0; b < 4; b++) if (w2 && byteenable2[b]) mdl[address2][b*8 +: 8] = writedata2[b*8 +: 8];
    for (int b = 0; b < 4; b++) if (w1 && byteenable[b])  mdl[address][b*8 +: 8]  = writedata[b*8 +: 8];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (irq_w[d] !== exp_irq) begin
        errors++;
        $display("FAIL irq dut%0d cyc=%0d: got %b required %b", d, cyc, irq_w[d], exp_irq);
      end
      checks++;
      if (irq2_w[d] !== exp_irq2) begin
        errors++;
        $display("FAIL irq2 dut%0d cyc=%0d: got %b required %b", d, cyc, irq2_w[d], exp_irq2);
      end
    end
  endtask

  function automatic logic [AW-1:0] raddr();
    case ($urandom_range(3))
      0:       return AW'(MB);
      1:       return AW'(MB + 1);
      2:       return AW'($urandom_range(15));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1; final_chk = 0; iss = '0; iss_d[0] = '0; iss_d[1] = '0;
    exp_irq = 0; exp_irq2 = 0;
    idle();
    step(); step();
    reset = 0;

    // Fill the whole memory so every model word is known.
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_p1(0, 1, AW'(i), 4'hF, $urandom);
      set_p2(0, 1, AW'(i + DEPTH / 2), 4'hF, $urandom);
      step();
    end
    idle(); step();

    // Cross-port write then read.
    set_p1(0, 1, 5, 4'hF, 32'hDEADBEEF); step();
    idle(); set_p2(1, 0, 5, 4'h0, 32'h0); step();
    idle(); step(); step();

    // Back-to-back reads on port 1.
    for (int a = 1; a <= 3; a++) begin set_p1(1, 0, AW'(a), 4'h0, 32'h0); step(); end
    idle(); step(); step(); step();

    // Same-cycle byte-lane collision on address 9.
    set_p1(0, 1, 9, 4'h8, 32'h5A000000); step();
    set_p1(0, 1, 9, 4'h3, 32'h11223344); set_p2(0, 1, 9, 4'h6, 32'hAABBCCDD); step();
    idle(); set_p1(1, 0, 9, 4'h0, 32'h0); set_p2(1, 0, 9, 4'h0, 32'h0); step();
    idle(); step(); step();

    // Read+write on one port, and mixed-port read during write.
    set_p1(1, 1, 9, 4'hF, 32'h01020304); step();
    set_p1(0, 1, 12, 4'hF, 32'hCAFEF00D); set_p2(1, 0, 12, 4'h0, 32'h0); step();
    idle(); set_p2(1, 0, 12, 4'h0, 32'h0); step();
    idle(); step(); step();

    // Mailbox interrupts.
    set_p1(0, 1, AW'(MB), 4'hF, 32'h1); step();
    idle(); step();
    set_p2(1, 0, AW'(MB), 4'h0, 32'h0); step();
    idle(); set_p1(0, 1, AW'(MB), 4'hF, 32'h2); set_p2(1, 0, AW'(MB), 4'h0, 32'h0); step();
    idle(); set_p2(0, 1, AW'(MB + 1), 4'hF, 32'h3); step();
    idle(); set_p2(0, 1, AW'(MB), 4'hF, 32'h4); set_p1(0, 1, AW'(MB + 1), 4'hF, 32'h5); step();
    idle(); set_p1(1, 0, AW'(MB + 1), 4'h0, 32'h0); step();
    idle(); step(); step();

    // clken hold on both ports for three cycles with a read in flight.
    set_p1(1, 0, 7, 4'h0, 32'h0); set_p2(1, 0, 5, 4'h0, 32'h0); step();
    idle(); clken = 0; clken2 = 0; step(); step(); step();
    clken = 1; clken2 = 1; step(); step(); step();

    // Reset with reads in flight.
    set_p1(1, 0, 8, 4'h0, 32'h0); set_p2(1, 0, 9, 4'h0, 32'h0); step();
    idle(); reset = 1; step(); step();
    reset = 0; step(); step(); step();
    set_p1(1, 0, 8, 4'h0, 32'h0); step();
    idle(); step(); step();

    // reset_req blocks both reads and writes.
    reset_req = 1; set_p1(1, 1, 20, 4'hF, 32'h0BADBAD0); set_p2(1, 1, 21, 4'hF, 32'h0BADBAD1); step();
    idle(); set_p1(1, 0, 20, 4'h0, 32'h0); set_p2(1, 0, 21, 4'h0, 32'h0); step();
    idle(); step(); step();

    // Randomized traffic.
    for (int n = 0; n < 1000; n++) begin
      chipselect  = ($urandom_range(7) != 0); read  = 1'($urandom_range(1));
      write       = ($urandom_range(2) == 0); address = raddr();
      byteenable  = 4'($urandom); writedata = $urandom;
      chipselect2 = ($urandom_range(7) != 0); read2 = 1'($urandom_range(1));
      write2      = ($urandom_range(2) == 0); address2 = raddr();
      byteenable2 = 4'($urandom); writedata2 = $urandom;
      clken       = ($urandom_range(5) != 0); clken2 = ($urandom_range(5) != 0);
      reset_req   = ($urandom_range(39) == 0);
      step();
    end

    idle();
    repeat (4) step();
    final_chk = 1;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
